fetch_unit: RTL and testbench

Instruction fetch stage of the downsampling processor. It owns the program counter and drives the instruction memory's address and FETCH strobe. It captures the returned byte(s) into an opcode/operand instruction register and presents them to the control unit over a valid/ready handshake. It supports one- and two-byte instructions, PC redirects for jumps, and a halt opcode.

---
 rtl/proc_pkg.sv | 9 +
 rtl/fetch_unit.sv | 61 ++++++
 tb/tb_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared constants, widths and fetch state encoding for the downsampling processor
package proc_pkg;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [AW-1:0] RESET_PC = 8'h00;
  localparam logic [DW-1:0] HALT_OP = 8'hFF;
  localparam int LONG_BIT = 7;
  typedef enum logic [2:0] {IDLE, F_OP, C_OP, C_OPR, ISSUE, HALT} state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch FSM; drives iAddr/FETCH, captures instr into ir/opr, issues via ir_valid/ir_ready, pc_load redirect, halt on HALT_OP
module fetch_unit
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] iAddr,
  output logic          FETCH,
  input  logic [DW-1:0] instr,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] opr,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_target,
  output logic [AW-1:0] pc,
  output logic          halted
);
  state_t state;
  logic long_op;
  assign long_op = instr != HALT_OP && instr[LONG_BIT];
  assign iAddr = pc;
  assign FETCH = state == F_OP || (state == C_OP && long_op);
  assign ir_valid = state == ISSUE;
  assign halted = state == HALT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      opr <= '0;
    end else begin
      case (state)
        IDLE: state <= start ? F_OP : IDLE;
        F_OP: begin
          pc <= pc + 1'b1;
          state <= C_OP;
        end
        C_OP: begin
          ir <= instr;
          opr <= long_op ? opr : '0;
          pc <= long_op ? pc + 1'b1 : pc;
          state <= long_op ? C_OPR : ISSUE;
        end
        C_OPR: begin
          opr <= instr;
          state <= ISSUE;
        end
        ISSUE: if (ir_ready) begin
          state <= ir == HALT_OP ? HALT : F_OP;
          pc <= (ir != HALT_OP && pc_load) ? pc_target : pc;
        end
        HALT: if (start) begin
          pc <= RESET_PC;
          state <= F_OP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a registered instruction memory model
module tb_fetch_unit;
  logic clk = 0, rst_n = 0, start = 0, ir_ready = 0, pc_load = 0;
  logic [7:0] pc_target = 0, instr = 0;
  logic [7:0] iAddr, ir, opr, pc;
  logic FETCH, ir_valid, halted;
  logic [7:0] mem [256];
  int tests = 0, failed = 0;
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iAddr(iAddr), .FETCH(FETCH),
    .instr(instr), .ir(ir), .opr(opr), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc_load(pc_load), .pc_target(pc_target), .pc(pc), .halted(halted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) instr <= mem[iAddr];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h11; mem[8'h02] = 8'h85; mem[8'h03] = 8'h3C;
    mem[8'h04] = 8'h20; mem[8'h05] = 8'h21; mem[8'h40] = 8'h30; mem[8'hFF] = 8'h90;
    #12;
    chk("rst_pc", pc, 8'h00); chk("rst_iaddr", iAddr, 8'h00); chk("rst_fetch", {7'd0, FETCH}, 8'h00);
    chk("rst_ir", ir, 8'h00); chk("rst_opr", opr, 8'h00); chk("rst_valid", {7'd0, ir_valid}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    rst_n = 1;
    tick(); tick();
    chk("idle_fetch", {7'd0, FETCH}, 8'h00);
    start = 1; ir_ready = 1;
    tick();
    start = 0;
    chk("f0_fetch", {7'd0, FETCH}, 8'h01); chk("f0_addr", iAddr, 8'h00);
    tick();
    chk("c0_fetch", {7'd0, FETCH}, 8'h00); chk("c0_valid", {7'd0, ir_valid}, 8'h00);
    tick();
    chk("i0_valid", {7'd0, ir_valid}, 8'h01); chk("i0_ir", ir, 8'h10); chk("i0_opr", opr, 8'h00);
    chk("i0_pc", pc, 8'h01); chk("i0_fetch", {7'd0, FETCH}, 8'h00);
    tick();
    chk("f1_addr", iAddr, 8'h01); chk("f1_fetch", {7'd0, FETCH}, 8'h01);
    tick(); tick();
    chk("i1_valid", {7'd0, ir_valid}, 8'h01); chk("i1_ir", ir, 8'h11);
    tick();
    chk("f2_addr", iAddr, 8'h02);
    tick();
    chk("c2_fetch", {7'd0, FETCH}, 8'h01); chk("c2_addr", iAddr, 8'h03);
    tick();
    chk("c2r_valid", {7'd0, ir_valid}, 8'h00); chk("c2r_fetch", {7'd0, FETCH}, 8'h00);
    ir_ready = 0;
    tick();
    chk("i2_valid", {7'd0, ir_valid}, 8'h01); chk("i2_ir", ir, 8'h85); chk("i2_opr", opr, 8'h3C);
    chk("i2_pc", pc, 8'h04);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {7'd0, ir_valid}, 8'h01); chk("bp_ir", ir, 8'h85); chk("bp_opr", opr, 8'h3C);
      chk("bp_fetch", {7'd0, FETCH}, 8'h00);
    end
    ir_ready = 1;
    tick();
    chk("res_fetch", {7'd0, FETCH}, 8'h01); chk("res_addr", iAddr, 8'h04);
    tick();
    pc_load = 1; pc_target = 8'h77;
    tick();
    chk("ign_ir", ir, 8'h20); chk("ign_pc", pc, 8'h05);
    pc_target = 8'h40;
    tick();
    pc_load = 0;
    chk("rd_fetch", {7'd0, FETCH}, 8'h01); chk("rd_addr", iAddr, 8'h40);
    tick(); tick();
    chk("rd_ir", ir, 8'h30);
    pc_load = 1; pc_target = 8'hFF;
    tick();
    pc_load = 0;
    mem[8'h00] = 8'h22; mem[8'h01] = 8'hFF;
    chk("wr_addr", iAddr, 8'hFF);
    tick();
    chk("wr_opfetch", {7'd0, FETCH}, 8'h01); chk("wr_opaddr", iAddr, 8'h00);
    tick(); tick();
    chk("wr_ir", ir, 8'h90); chk("wr_opr", opr, 8'h22); chk("wr_pc", pc, 8'h01);
    tick();
    chk("h_addr", iAddr, 8'h01);
    tick();
    chk("h_cfetch", {7'd0, FETCH}, 8'h00);
    pc_load = 1; pc_target = 8'h55;
    tick();
    chk("h_ir", ir, 8'hFF); chk("h_opr", opr, 8'h00); chk("h_prehalt", {7'd0, halted}, 8'h00);
    tick();
    pc_load = 0;
    chk("h_halted", {7'd0, halted}, 8'h01); chk("h_pc", pc, 8'h02); chk("h_fetch", {7'd0, FETCH}, 8'h00);
    tick(); tick();
    chk("h_hold", {7'd0, halted}, 8'h01); chk("h_fetch2", {7'd0, FETCH}, 8'h00);
    mem[8'h00] = 8'h9A; mem[8'h01] = 8'h55;
    start = 1;
    tick();
    start = 0;
    chk("rs_halted", {7'd0, halted}, 8'h00); chk("rs_addr", iAddr, 8'h00); chk("rs_fetch", {7'd0, FETCH}, 8'h01);
    tick();
    chk("rs_opaddr", iAddr, 8'h01); chk("rs_opfetch", {7'd0, FETCH}, 8'h01);
    tick();
    chk("rs_ir", ir, 8'h9A);
    #2 rst_n = 0;
    #1;
    chk("ar_pc", pc, 8'h00); chk("ar_iaddr", iAddr, 8'h00); chk("ar_ir", ir, 8'h00); chk("ar_opr", opr, 8'h00);
    chk("ar_fetch", {7'd0, FETCH}, 8'h00); chk("ar_valid", {7'd0, ir_valid}, 8'h00);
    chk("ar_halted", {7'd0, halted}, 8'h00);
    rst_n = 1;
    tick(); tick();
    chk("post_fetch", {7'd0, FETCH}, 8'h00); chk("post_valid", {7'd0, ir_valid}, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
